// File: rtl/fetch.sv
// Instruction fetch front end: issues word-aligned requests under a credit limit,
// matches in-order responses against an epoch-tagged queue and buffers them for decode.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        stall,
  output logic [31:0] instr_out,
  output logic [31:0] instr_addr_out,
  output logic        instr_valid
);

  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic          epoch_q, epoch_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;

  logic [31:0]   tag_addr_q [DEPTH];
  logic          tag_ep_q   [DEPTH];
  logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [31:0]   buf_addr_q  [DEPTH];
  logic [31:0]   buf_instr_q [DEPTH];
  logic [PW-1:0] buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
  logic [CW-1:0] buf_cnt_q, buf_cnt_d;

  logic [CW:0]   credits_used;
  logic          req_fire, rsp_take, rsp_keep, buf_pop;
  logic          unused_redir_lsb;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign unused_redir_lsb = ^redirect_addr[1:0];

  // Credits cover both in-flight requests and buffered instructions, so the
  // buffer always has room for every response that can come back.
  assign credits_used   = {1'b0, out_cnt_q} + {1'b0, buf_cnt_q};
  assign imem_req_valid = !rst_n && !redirect_valid && (credits_used < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_take       = !rst_n && imem_rsp_valid && (out_cnt_q != '0);
  assign rsp_keep       = rsp_take && (tag_ep_q[tag_rd_q] == epoch_q) && !redirect_valid;

  assign instr_valid    = !rst_n && (buf_cnt_q != '0);
  assign instr_out      = instr_valid ? buf_instr_q[buf_rd_q] : NOP;
  assign instr_addr_out = instr_valid ? buf_addr_q[buf_rd_q]  : '0;
  assign buf_pop        = instr_valid && !stall;

  always_comb begin
    pc_d      = pc_q;
    epoch_d   = epoch_q;
    out_cnt_d = out_cnt_q;
    tag_rd_d  = tag_rd_q;
    tag_wr_d  = tag_wr_q;
    buf_rd_d  = buf_rd_q;
    buf_wr_d  = buf_wr_q;
    buf_cnt_d = buf_cnt_q;

    if (req_fire) begin
      pc_d     = pc_q + 32'd4;
      tag_wr_d = ptr_inc(tag_wr_q);
    end
    if (rsp_take) tag_rd_d = ptr_inc(tag_rd_q);
    case ({req_fire, rsp_take})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase

    // Redirect keeps the tag queue intact; only the epoch flip marks old responses stale.
    if (redirect_valid) begin
      pc_d      = {redirect_addr[31:2], 2'b00};
      epoch_d   = !epoch_q;
      buf_rd_d  = '0;
      buf_wr_d  = '0;
      buf_cnt_d = '0;
    end else begin
      if (rsp_keep) buf_wr_d = ptr_inc(buf_wr_q);
      if (buf_pop)  buf_rd_d = ptr_inc(buf_rd_q);
      case ({rsp_keep, buf_pop})
        2'b10:   buf_cnt_d = buf_cnt_q + 1'b1;
        2'b01:   buf_cnt_d = buf_cnt_q - 1'b1;
        default: buf_cnt_d = buf_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc_q      <= RESET_PC;
      epoch_q   <= 1'b0;
      out_cnt_q <= '0;
      tag_rd_q  <= '0;
      tag_wr_q  <= '0;
      buf_rd_q  <= '0;
      buf_wr_q  <= '0;
      buf_cnt_q <= '0;
    end else begin
      pc_q      <= pc_d;
      epoch_q   <= epoch_d;
      out_cnt_q <= out_cnt_d;
      tag_rd_q  <= tag_rd_d;
      tag_wr_q  <= tag_wr_d;
      buf_rd_q  <= buf_rd_d;
      buf_wr_q  <= buf_wr_d;
      buf_cnt_q <= buf_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_addr_q[tag_wr_q] <= pc_q;
      tag_ep_q[tag_wr_q]   <= epoch_q;
    end
    if (rsp_keep) begin
      buf_addr_q[buf_wr_q]  <= tag_addr_q[tag_rd_q];
      buf_instr_q[buf_wr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios then random traffic, checked against a
// queue-based reference model; a second instance covers PC wrap-around.
module tb_fetch;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk, rst, ready, rsp_valid, redirect, stall;
  logic [31:0] rsp_data, redirect_addr;
  logic        req_valid, instr_valid, req_valid2, instr_valid2;
  logic [31:0] req_addr, instr_out, instr_addr;
  logic [31:0] req_addr2, instr_out2, unused_instr_addr2;

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [31:0] addr; logic ep; } tag_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] ins; } ent_t;

  tag_t        inflight[$];
  ent_t        fifo[$];
  logic [31:0] m_pc  = 32'h0;
  logic [31:0] m_pc2 = WRAP_PC;
  logic        m_ep  = 1'b0;
  logic [31:0] dut_fired1[$];
  logic [31:0] dut_fired2[$];

  fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst),
    .imem_req_valid(req_valid), .imem_req_ready(ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redirect), .redirect_addr(redirect_addr), .stall(stall),
    .instr_out(instr_out), .instr_addr_out(instr_addr), .instr_valid(instr_valid)
  );

  fetch #(.RESET_PC(WRAP_PC), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst),
    .imem_req_valid(req_valid2), .imem_req_ready(ready), .imem_req_addr(req_addr2),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redirect), .redirect_addr(redirect_addr), .stall(stall),
    .instr_out(instr_out2), .instr_addr_out(unused_instr_addr2), .instr_valid(instr_valid2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_rv();
    return !rst && !redirect && (inflight.size() + fifo.size() < DEPTH);
  endfunction

  task automatic drive(input bit r, input bit rdy, input bit respond, input bit stl,
                       input bit redir, input logic [31:0] raddr);
    rst           = r;
    ready         = rdy;
    rsp_valid     = respond && (inflight.size() > 0);
    rsp_data      = $urandom;
    stall         = stl;
    redirect      = redir;
    redirect_addr = raddr;
  endtask

  task automatic check_outputs();
    logic        ev;
    logic [31:0] eo, ea;
    ev = !rst && (fifo.size() > 0);
    eo = ev ? fifo[0].ins  : NOP;
    ea = ev ? fifo[0].addr : 32'h0;
    chk("req_valid",    req_valid,   exp_rv());
    chk("req_valid2",   req_valid2,  exp_rv());
    if (!rst) begin
      chk("req_addr",  req_addr,  m_pc);
      chk("req_addr2", req_addr2, m_pc2);
    end
    chk("instr_valid",  instr_valid,  ev);
    chk("instr_out",    instr_out,    eo);
    chk("instr_addr",   instr_addr,   ea);
    chk("instr_valid2", instr_valid2, ev);
    chk("instr_out2",   instr_out2,   eo);
    if (req_valid === 1'b1 && ready)  dut_fired1.push_back(req_addr);
    if (req_valid2 === 1'b1 && ready) dut_fired2.push_back(req_addr2);
  endtask

  task automatic model_update();
    bit   fire, keep;
    tag_t t;
    ent_t e;
    if (rst) begin
      inflight.delete();
      fifo.delete();
      dut_fired1.delete();
      dut_fired2.delete();
      m_pc  = 32'h0;
      m_pc2 = WRAP_PC;
      m_ep  = 1'b0;
      return;
    end
    fire = exp_rv() && ready;
    keep = 1'b0;
    if (rsp_valid && inflight.size() > 0) begin
      t    = inflight.pop_front();
      keep = (t.ep == m_ep) && !redirect;
    end
    if (fifo.size() > 0 && !stall) void'(fifo.pop_front());
    if (keep) begin
      e.addr = t.addr;
      e.ins  = rsp_data;
      fifo.push_back(e);
    end
    if (fire) begin
      t.addr = m_pc;
      t.ep   = m_ep;
      inflight.push_back(t);
      m_pc  = m_pc + 32'd4;
      m_pc2 = m_pc2 + 32'd4;
    end
    if (redirect) begin
      fifo.delete();
      m_pc  = {redirect_addr[31:2], 2'b00};
      m_pc2 = m_pc;
      m_ep  = !m_ep;
    end
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (inflight.size() > 0 || fifo.size() > 0); i++) begin
      drive(0, 0, 1, 0, 0, 32'h0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 32'h0);
    #1;
    chk("drained_instr_valid", instr_valid, 1'b0);
  endtask

  logic [31:0] exp_seq1 [3];
  logic [31:0] exp_seq2 [3];
  bit          found;

  initial begin
    exp_seq1 = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    exp_seq2 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    drive(1, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    repeat (2) cycle();

    // reset release with a 1-cycle memory
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 1, 0, 0, 32'h0);
      #1;
      if (k == 0) begin
        chk("first_req_valid", req_valid, 1'b1);
        chk("first_req_addr",  req_addr,  32'h0);
        chk("first_req_addr2", req_addr2, WRAP_PC);
      end
      if (k == 1) chk("no_instr_yet", instr_valid, 1'b0);
      if (k == 2) begin
        chk("first_instr_valid", instr_valid, 1'b1);
        chk("first_instr_addr",  instr_addr,  32'h0);
      end
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      chk("req_seq",  dut_fired1[i], exp_seq1[i]);
      chk("wrap_seq", dut_fired2[i], exp_seq2[i]);
    end

    // stall held 4 cycles
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, 1, 0, 32'h0);
      #1;
      if (k == 3) begin
        chk("stall_no_req",    req_valid,   1'b0);
        chk("stall_buf_valid", instr_valid, 1'b1);
      end
      cycle();
    end
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 1, 0, 0, 32'h0);
      cycle();
    end

    // redirect with two requests outstanding
    drain();
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 0, 0, 0, 32'h0);
      cycle();
    end
    drive(0, 1, 0, 0, 1, 32'h0000_0103);
    #1;
    chk("redir_no_req", req_valid, 1'b0);
    cycle();
    drive(0, 1, 0, 0, 0, 32'h0);
    #1;
    chk("redir_pc", req_addr, 32'h0000_0100);
    cycle();
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      drive(0, 1, 1, 0, 0, 32'h0);
      #1;
      if (instr_valid === 1'b1) begin
        found = 1'b1;
        chk("redir_first_addr", instr_addr, 32'h0000_0100);
      end
      cycle();
    end
    chk("redir_first_instr_seen", found, 1'b1);

    // redirect in the same cycle as a current-epoch response
    drain();
    drive(0, 1, 0, 0, 0, 32'h0);
    cycle();
    drive(0, 0, 1, 1, 1, 32'h0000_2000);
    #1;
    chk("redir_rsp_is_valid", rsp_valid, 1'b1);
    cycle();
    drive(0, 0, 0, 0, 0, 32'h0);
    #1;
    chk("redir_rsp_dropped", instr_valid, 1'b0);
    cycle();

    // redirect while stalled with a full buffer
    drain();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, 1, 0, 32'h0);
      cycle();
    end
    drive(0, 0, 0, 1, 1, 32'h0000_3000);
    #1;
    chk("stall_redir_full", instr_valid, 1'b1);
    cycle();
    drive(0, 0, 0, 1, 0, 32'h0);
    #1;
    chk("stall_redir_clear", instr_valid, 1'b0);
    cycle();

    // spurious responses with nothing outstanding
    drain();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 32'h0);
      rsp_valid = 1'b1;
      #1;
      chk("spur_instr_valid", instr_valid, 1'b0);
      cycle();
    end
    drive(0, 1, 0, 0, 0, 32'h0);
    #1;
    chk("spur_credit", req_valid, 1'b1);
    cycle();

    // mid-operation reset
    drive(0, 1, 1, 0, 0, 32'h0);
    cycle();
    drive(1, 1, 1, 0, 0, 32'h0);
    cycle();
    drive(0, 1, 1, 0, 0, 32'h0);
    #1;
    chk("post_reset_addr", req_addr, 32'h0);
    cycle();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, $urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
